microcode_store_loader: RTL and testbench

- Microcode control store that supplies the 24-bit microword MW to the control section, indexed by the MICROADDRESS it drives.
- Includes a byte-serial loader FSM that writes microprograms into the store through a valid/ready handshake.
- While loading, it holds the processor and presents a NOP microword.
- Completion is signalled only after a checksum over the load stream passes.

---
 rtl/microcode_store_loader.sv | 203 ++++++++++++++++++++
 tb/tb_microcode_store_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_store_loader.sv
// -----------------------------------------------------------------------------
// microcode_store_loader
//
// Microcode control store (256 x 24) with a byte-serial loader. While idle,
// the store feeds the control section combinationally from MICROADDRESS.
// While a load session is active, the processor is held, MW is forced to the
// NOP word, and a valid/ready byte stream is unpacked into the store. The
// session reports success only if the 8-bit sum of every accepted byte,
// including the trailing checksum byte, is zero.
//
// Stream: START_ADDR, COUNT (0 = 256 words), COUNT x {b23_16, b15_8, b7_0}, CHK
//
// Ports:
//   SYSTEM_CLK    in   1   system clock, rising-edge active
//   RESET         in   1   synchronous, active-high reset
//   MICROADDRESS  in   8   microword address from the control section
//   MW            out  24  microword to the control section
//   LOAD_MODE     in   1   level; requests and sustains a load session
//   LOAD_VALID    in   1   LOAD_BYTE is valid this cycle
//   LOAD_BYTE     in   8   load stream byte
//   LOAD_READY    out  1   loader accepts a byte this cycle
//   LOAD_ADDR     out  8   store address of the next word to be written
//   CPU_HOLD      out  1   processor stall while the loader is busy
//   LOAD_DONE     out  1   sticky; last session completed with good checksum
//   LOAD_ERR      out  1   sticky; last session failed (bad checksum / abort)
// -----------------------------------------------------------------------------
module microcode_store_loader #(
    parameter logic [23:0] NOP_WORD = 24'h000000
) (
    input  logic        SYSTEM_CLK,
    input  logic        RESET,
    input  logic [7:0]  MICROADDRESS,
    output logic [23:0] MW,
    input  logic        LOAD_MODE,
    input  logic        LOAD_VALID,
    input  logic [7:0]  LOAD_BYTE,
    output logic        LOAD_READY,
    output logic [7:0]  LOAD_ADDR,
    output logic        CPU_HOLD,
    output logic        LOAD_DONE,
    output logic        LOAD_ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_B2,
        S_B1,
        S_B0,
        S_CHK,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [8:0]  remaining_q, remaining_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  b2_q, b2_d;
    logic [7:0]  b1_q, b1_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [23:0] mem [256];

    logic        streaming;
    logic        accept;
    logic        wrEn;
    logic [7:0]  sumNext;

    // Next-state and handshake logic. LOAD_READY is gated by LOAD_MODE so a
    // byte offered in the same cycle as an abort is never consumed, and by
    // RESET so nothing is accepted while reset is asserted.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        b2_d        = b2_q;
        b1_d        = b1_q;
        done_d      = done_q;
        err_d       = err_q;
        wrEn        = 1'b0;

        streaming  = (state_q inside {S_ADDR, S_CNT, S_B2, S_B1, S_B0, S_CHK});
        LOAD_READY = streaming && LOAD_MODE && !RESET;
        accept     = LOAD_READY && LOAD_VALID;
        sumNext    = sum_q + LOAD_BYTE;

        if (streaming && !LOAD_MODE) begin
            // Abort: words already written stay in the store.
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (LOAD_MODE) begin
                        state_d = S_ADDR;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        sum_d   = 8'h00;
                    end
                end
                S_ADDR: begin
                    if (accept) begin
                        ptr_d   = LOAD_BYTE;
                        state_d = S_CNT;
                    end
                end
                S_CNT: begin
                    if (accept) begin
                        // A zero count encodes a full 256-word load.
                        remaining_d = (LOAD_BYTE == 8'h00) ? 9'd256 : {1'b0, LOAD_BYTE};
                        state_d     = S_B2;
                    end
                end
                S_B2: begin
                    if (accept) begin
                        b2_d    = LOAD_BYTE;
                        state_d = S_B1;
                    end
                end
                S_B1: begin
                    if (accept) begin
                        b1_d    = LOAD_BYTE;
                        state_d = S_B0;
                    end
                end
                S_B0: begin
                    if (accept) begin
                        wrEn        = 1'b1;
                        ptr_d       = ptr_q + 8'd1;
                        remaining_d = remaining_q - 9'd1;
                        state_d     = (remaining_q == 9'd1) ? S_CHK : S_B2;
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        if (sumNext == 8'h00) begin
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (!LOAD_MODE) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (accept) begin
                sum_d = sumNext;
            end
        end
    end

    // Loader state registers; reset discards any partially assembled word.
    always_ff @(posedge SYSTEM_CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            ptr_q       <= 8'h00;
            remaining_q <= 9'd0;
            sum_q       <= 8'h00;
            b2_q        <= 8'h00;
            b1_q        <= 8'h00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
            b2_q        <= b2_d;
            b1_q        <= b1_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Store write port. Contents survive reset; wrEn already excludes RESET.
    always_ff @(posedge SYSTEM_CLK) begin
        if (wrEn) begin
            mem[ptr_q] <= {b2_q, b1_q, LOAD_BYTE};
        end
    end

    // Read port. Writes only happen outside IDLE, when MW is the NOP word,
    // so a read can never observe a half-written location.
    always_comb begin
        MW        = (state_q == S_IDLE && !RESET) ? mem[MICROADDRESS] : NOP_WORD;
        LOAD_ADDR = ptr_q;
        CPU_HOLD  = (state_q != S_IDLE);
        LOAD_DONE = done_q;
        LOAD_ERR  = err_q;
    end

endmodule

// File: tb/tb_microcode_store_loader.sv
// -----------------------------------------------------------------------------
// tb_microcode_store_loader
//
// Self-checking bench for microcode_store_loader. A transaction-level model
// tracks each session by the index of the accepted byte within the stream
// and keeps an image of the store; a compare process checks every output on
// every falling edge. Directed scenarios pin the model with literal values,
// followed by randomized sessions (good, bad checksum, abort) with gaps.
// -----------------------------------------------------------------------------
module tb_microcode_store_loader;

    logic        SYSTEM_CLK = 1'b0;
    logic        RESET;
    logic [7:0]  MICROADDRESS;
    logic [23:0] MW;
    logic        LOAD_MODE;
    logic        LOAD_VALID;
    logic [7:0]  LOAD_BYTE;
    logic        LOAD_READY;
    logic [7:0]  LOAD_ADDR;
    logic        CPU_HOLD;
    logic        LOAD_DONE;
    logic        LOAD_ERR;

    int nChecks = 0;
    int nFail   = 0;
    bit checkEn = 1'b0;

    // Model state: phase 0 = idle, 1 = accepting stream, 2 = finished and
    // waiting for LOAD_MODE to drop.
    int          mPhase = 0;
    int          mIdx   = 0;
    int          mCount = 0;
    logic [7:0]  mPtr   = 8'h00;
    logic [7:0]  mSum   = 8'h00;
    logic [23:0] mWord  = 24'h0;
    bit          mDone  = 1'b0;
    bit          mErr   = 1'b0;
    logic [23:0] mMem   [256];
    bit          mKnown [256];

    logic [23:0] wordBuf [256];
    logic [7:0]  sessSum;

    microcode_store_loader #(.NOP_WORD(24'h000000)) dut (
        .SYSTEM_CLK  (SYSTEM_CLK),
        .RESET       (RESET),
        .MICROADDRESS(MICROADDRESS),
        .MW          (MW),
        .LOAD_MODE   (LOAD_MODE),
        .LOAD_VALID  (LOAD_VALID),
        .LOAD_BYTE   (LOAD_BYTE),
        .LOAD_READY  (LOAD_READY),
        .LOAD_ADDR   (LOAD_ADDR),
        .CPU_HOLD    (CPU_HOLD),
        .LOAD_DONE   (LOAD_DONE),
        .LOAD_ERR    (LOAD_ERR)
    );

    always #5 SYSTEM_CLK = ~SYSTEM_CLK;

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model, advanced on each rising edge from the inputs that
    // were stable across it.
    always @(posedge SYSTEM_CLK) begin
        if (RESET) begin
            mPhase = 0;
            mIdx   = 0;
            mPtr   = 8'h00;
            mSum   = 8'h00;
            mDone  = 1'b0;
            mErr   = 1'b0;
        end else if (mPhase == 0) begin
            if (LOAD_MODE) begin
                mPhase = 1;
                mIdx   = 0;
                mSum   = 8'h00;
                mDone  = 1'b0;
                mErr   = 1'b0;
            end
        end else if (mPhase == 1) begin
            if (!LOAD_MODE) begin
                mPhase = 0;
                mErr   = 1'b1;
            end else if (LOAD_VALID) begin
                if (mIdx == 0) begin
                    mPtr = LOAD_BYTE;
                end else if (mIdx == 1) begin
                    mCount = (LOAD_BYTE == 8'h00) ? 256 : int'(LOAD_BYTE);
                end else if (mIdx < 2 + 3 * mCount) begin
                    mWord = {mWord[15:0], LOAD_BYTE};
                    if ((mIdx - 2) % 3 == 2) begin
                        mMem[mPtr]   = mWord;
                        mKnown[mPtr] = 1'b1;
                        mPtr         = mPtr + 8'd1;
                    end
                end else begin
                    if (8'(mSum + LOAD_BYTE) == 8'h00) mDone = 1'b1;
                    else                               mErr  = 1'b1;
                    mPhase = 2;
                end
                mSum = mSum + LOAD_BYTE;
                mIdx++;
            end
        end else begin
            if (!LOAD_MODE) mPhase = 0;
        end
    end

    // Compare process: every output, every cycle, at the falling edge.
    always @(negedge SYSTEM_CLK) begin
        if (checkEn) begin
            checkOutput("CPU_HOLD", 32'(CPU_HOLD), 32'(mPhase != 0));
            checkOutput("LOAD_READY", 32'(LOAD_READY), 32'(!RESET && mPhase == 1 && LOAD_MODE));
            checkOutput("LOAD_ADDR", 32'(LOAD_ADDR), 32'(mPtr));
            checkOutput("LOAD_DONE", 32'(LOAD_DONE), 32'(mDone));
            checkOutput("LOAD_ERR", 32'(LOAD_ERR), 32'(mErr));
            if (RESET || mPhase != 0) begin
                checkOutput("MW_nop", 32'(MW), 32'h0);
            end else if (mKnown[MICROADDRESS]) begin
                checkOutput("MW_read", 32'(MW), 32'(mMem[MICROADDRESS]));
            end
        end
    end

    // Offer one byte and hold it until the loader takes it (bounded wait).
    task automatic applyStimulus(input logic [7:0] b);
        int  waitCnt = 0;
        bit  taken   = 1'b0;
        LOAD_VALID   = 1'b1;
        LOAD_BYTE    = b;
        MICROADDRESS = 8'($urandom);
        while (!taken && waitCnt < 20) begin
            @(negedge SYSTEM_CLK);
            taken = LOAD_READY;
            @(posedge SYSTEM_CLK);
            #1;
            waitCnt++;
        end
        if (!taken) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL handshake_timeout: byte %h not taken, expected accept within 20 cycles", b);
        end
        LOAD_VALID = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        LOAD_VALID = 1'b0;
        repeat (n) begin
            LOAD_BYTE    = 8'($urandom);
            MICROADDRESS = 8'($urandom);
            @(posedge SYSTEM_CLK);
            #1;
        end
    endtask

    // gapMode 0: back to back, 1: two idle cycles between bytes, 2: random.
    task automatic sendTracked(input logic [7:0] b, input int gapMode);
        applyStimulus(b);
        sessSum = sessSum + b;
        if (gapMode == 1)      idleCycles(2);
        else if (gapMode == 2) idleCycles(int'($urandom_range(0, 2)));
    endtask

    // Full session from wordBuf; chkAdj != 0 corrupts the checksum.
    task automatic loadSession(input logic [7:0] start, input int count,
                               input logic [7:0] chkAdj, input int gapMode);
        sessSum   = 8'h00;
        LOAD_MODE = 1'b1;
        sendTracked(start, gapMode);
        sendTracked(8'(count), gapMode);
        for (int i = 0; i < count; i++) begin
            sendTracked(wordBuf[i][23:16], gapMode);
            sendTracked(wordBuf[i][15:8], gapMode);
            sendTracked(wordBuf[i][7:0], gapMode);
        end
        applyStimulus(8'(8'h00 - sessSum + chkAdj));
        LOAD_MODE = 1'b0;
        @(posedge SYSTEM_CLK);
        #1;
    endtask

    // Session dropped after nData data bytes.
    task automatic abortSession(input logic [7:0] start, input logic [7:0] cnt, input int nData);
        LOAD_MODE = 1'b1;
        applyStimulus(start);
        applyStimulus(cnt);
        for (int i = 0; i < nData; i++) applyStimulus(8'($urandom));
        LOAD_MODE  = 1'b0;
        LOAD_VALID = 1'b1;
        @(posedge SYSTEM_CLK);
        #1;
        LOAD_VALID = 1'b0;
    endtask

    task automatic readMw(input logic [7:0] addr, input logic [23:0] expected, input string name);
        MICROADDRESS = addr;
        @(negedge SYSTEM_CLK);
        checkOutput(name, 32'(MW), 32'(expected));
        @(posedge SYSTEM_CLK);
        #1;
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESET        = 1'b1;
        LOAD_MODE    = 1'b0;
        LOAD_VALID   = 1'b0;
        LOAD_BYTE    = 8'h00;
        MICROADDRESS = 8'h00;
        @(posedge SYSTEM_CLK);
        #1;
        checkEn = 1'b1;
        repeat (2) begin
            @(posedge SYSTEM_CLK);
            #1;
        end
        @(negedge SYSTEM_CLK);
        checkOutput("reset_MW", 32'(MW), 32'h0);
        checkOutput("reset_HOLD", 32'(CPU_HOLD), 32'd0);
        checkOutput("reset_READY", 32'(LOAD_READY), 32'd0);
        checkOutput("reset_DONE", 32'(LOAD_DONE), 32'd0);
        checkOutput("reset_ERR", 32'(LOAD_ERR), 32'd0);
        @(posedge SYSTEM_CLK);
        #1;
        RESET = 1'b0;
        idleCycles(2);

        // Full 256-word load (COUNT=0) so every address has a known value.
        for (int i = 0; i < 256; i++) wordBuf[i] = 24'($urandom);
        loadSession(8'($urandom), 256, 8'h00, 0);
        checkOutput("full_DONE", 32'(LOAD_DONE), 32'd1);

        // Good end-to-end load: 10,02,12,34,56,AB,CD,EF,EB.
        wordBuf[0] = 24'h123456;
        wordBuf[1] = 24'hABCDEF;
        loadSession(8'h10, 2, 8'h00, 0);
        checkOutput("good_DONE", 32'(LOAD_DONE), 32'd1);
        checkOutput("good_ERR", 32'(LOAD_ERR), 32'd0);
        readMw(8'h10, 24'h123456, "good_mw10");
        readMw(8'h11, 24'hABCDEF, "good_mw11");

        // Scribble 0x10, then the same stream with CHK=EA must still write it.
        wordBuf[0] = 24'h5A5A5A;
        loadSession(8'h10, 1, 8'h00, 0);
        readMw(8'h10, 24'h5A5A5A, "scribble_mw10");
        wordBuf[0] = 24'h123456;
        wordBuf[1] = 24'hABCDEF;
        loadSession(8'h10, 2, 8'hFF, 0);
        checkOutput("bad_ERR", 32'(LOAD_ERR), 32'd1);
        checkOutput("bad_DONE", 32'(LOAD_DONE), 32'd0);
        readMw(8'h10, 24'h123456, "bad_mw10");

        // Address wrap FE -> FF -> 00.
        wordBuf[0] = 24'h111111;
        wordBuf[1] = 24'h222222;
        wordBuf[2] = 24'h333333;
        loadSession(8'hFE, 3, 8'h00, 0);
        checkOutput("wrap_ADDR", 32'(LOAD_ADDR), 32'h01);
        readMw(8'hFE, 24'h111111, "wrap_mwFE");
        readMw(8'hFF, 24'h222222, "wrap_mwFF");
        readMw(8'h00, 24'h333333, "wrap_mw00");

        // Gapped stream must give the same contents as the gap-free one.
        wordBuf[0] = 24'h123456;
        wordBuf[1] = 24'hABCDEF;
        loadSession(8'h30, 2, 8'h00, 1);
        checkOutput("gap_DONE", 32'(LOAD_DONE), 32'd1);
        readMw(8'h30, 24'h123456, "gap_mw30");
        readMw(8'h31, 24'hABCDEF, "gap_mw31");

        // Abort after the B1 byte; a byte offered with the drop is ignored.
        abortSession(8'h10, 8'h01, 2);
        @(negedge SYSTEM_CLK);
        checkOutput("abort_ERR", 32'(LOAD_ERR), 32'd1);
        checkOutput("abort_HOLD", 32'(CPU_HOLD), 32'd0);
        @(posedge SYSTEM_CLK);
        #1;
        readMw(8'h10, 24'h123456, "abort_mw10");

        // Reset while the loader sits in B0 of the second word.
        LOAD_MODE = 1'b1;
        applyStimulus(8'h11);
        applyStimulus(8'h02);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        applyStimulus(8'hCC);
        applyStimulus(8'hDD);
        applyStimulus(8'hEE);
        RESET      = 1'b1;
        LOAD_MODE  = 1'b0;
        LOAD_VALID = 1'b1;
        @(negedge SYSTEM_CLK);
        checkOutput("rst_mid_MW", 32'(MW), 32'h0);
        checkOutput("rst_mid_READY", 32'(LOAD_READY), 32'd0);
        @(posedge SYSTEM_CLK);
        #1;
        LOAD_VALID = 1'b0;
        @(negedge SYSTEM_CLK);
        checkOutput("rst_after_HOLD", 32'(CPU_HOLD), 32'd0);
        checkOutput("rst_after_DONE", 32'(LOAD_DONE), 32'd0);
        checkOutput("rst_after_ERR", 32'(LOAD_ERR), 32'd0);
        checkOutput("rst_after_ADDR", 32'(LOAD_ADDR), 32'h00);
        @(posedge SYSTEM_CLK);
        #1;
        RESET = 1'b0;
        idleCycles(1);
        readMw(8'h10, 24'h123456, "rst_mw10");
        readMw(8'h11, 24'hAABBCC, "rst_mw11");

        // Randomized sessions checked by the model.
        for (int s = 0; s < 16; s++) begin
            int cnt;
            int kind;
            cnt  = int'($urandom_range(1, 6));
            kind = int'($urandom_range(0, 5));
            for (int i = 0; i < cnt; i++) wordBuf[i] = 24'($urandom);
            if (kind == 0) begin
                loadSession(8'($urandom), cnt, 8'($urandom_range(1, 255)), 2);
            end else if (kind == 1) begin
                abortSession(8'($urandom), 8'(cnt), int'($urandom_range(0, 3 * cnt)));
            end else begin
                loadSession(8'($urandom), cnt, 8'h00, 2);
            end
            idleCycles(int'($urandom_range(3, 10)));
        end

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
